// File: rtl/gift_ise_mc.sv
// GIFT ISE multi-cycle unit: key_updstd in 1 cycle, permbits_step (4 swapmoves + rotate) in 5 cycles,
// or 3 when GIFT_ISE_MC_UNROLL2_EN is defined; one op in flight, DONE holds until rsp_ready, flush aborts.
module gift_ise_mc (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_rs1,
  input  logic [4:0]  req_imm,
  input  logic        req_op_key_updstd,
  input  logic        req_op_permbits_step,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd,
  input  logic        flush
);

  typedef enum logic [1:0] {S_IDLE, S_SM, S_ROT, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_x, w_x_nxt;
  logic [1:0]  r_step, w_step_nxt;
  logic [4:0]  r_imm, w_imm_nxt;

  function automatic logic [31:0] f_swapmove(input logic [31:0] x, input logic [1:0] step);
    logic [31:0] m;
    logic [4:0]  a;
    logic [31:0] t;
    case (step)
      2'd0:    begin a = 5'd3;  m = 32'h0a0a0a0a; end
      2'd1:    begin a = 5'd6;  m = 32'h00cc00cc; end
      2'd2:    begin a = 5'd12; m = 32'h0000f0f0; end
      default: begin a = 5'd24; m = 32'h000000ff; end
    endcase
    t = (x ^ (x >> a)) & m;
    return x ^ t ^ (t << a);
  endfunction

  function automatic logic [31:0] f_key_updstd(input logic [31:0] x);
    return ((x >> 12) & 32'h0000000f) | ((x << 4)  & 32'h0000fff0) |
           ((x >> 2)  & 32'h3fff0000) | ((x << 14) & 32'hc0000000);
  endfunction

  function automatic logic [31:0] f_rotr(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_step_nxt  = r_step;
    w_imm_nxt   = r_imm;
    req_ready   = (r_state == S_IDLE);
    rsp_valid   = (r_state == S_DONE);
    rsp_rd      = (r_state == S_DONE) ? r_x : 32'h0;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_imm_nxt = req_imm;
          if (req_op_key_updstd && !req_op_permbits_step) begin
            w_x_nxt     = f_key_updstd(req_rs1);
            w_state_nxt = S_DONE;
          end else if (req_op_permbits_step && !req_op_key_updstd) begin
            w_x_nxt     = req_rs1;
            w_step_nxt  = 2'd0;
            w_state_nxt = S_SM;
          end else begin
            // Ambiguous op encoding completes immediately with a zero result.
            w_x_nxt     = 32'h0;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_SM: begin
`ifdef GIFT_ISE_MC_UNROLL2_EN
        w_x_nxt    = f_swapmove(f_swapmove(r_x, r_step), r_step + 2'd1);
        w_step_nxt = r_step + 2'd2;
        if (r_step == 2'd2) w_state_nxt = S_ROT;
`else
        w_x_nxt    = f_swapmove(r_x, r_step);
        w_step_nxt = r_step + 2'd1;
        if (r_step == 2'd3) w_state_nxt = S_ROT;
`endif
      end
      S_ROT: begin
        w_x_nxt     = f_rotr(r_x, r_imm);
        w_step_nxt  = 2'd0;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) begin
          w_x_nxt     = 32'h0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Flush outranks every transition, including acceptance in IDLE.
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_x_nxt     = 32'h0;
      w_step_nxt  = 2'd0;
      w_imm_nxt   = r_imm;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= S_IDLE;
      r_x     <= 32'h0;
      r_step  <= 2'd0;
      r_imm   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_step  <= w_step_nxt;
      r_imm   <= w_imm_nxt;
    end
  end

endmodule

// File: tb/tb_gift_ise_mc.sv
// Scoreboard bench for gift_ise_mc: randomized and directed requests against a bit-level reference model.
module tb_gift_ise_mc;

`ifdef GIFT_ISE_MC_UNROLL2_EN
  localparam int PLAT = 3;
`else
  localparam int PLAT = 5;
`endif

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_rs1 = 32'h0;
  logic [4:0]  req_imm = 5'd0;
  logic        req_op_key_updstd = 1'b0;
  logic        req_op_permbits_step = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rd;
  logic        flush = 1'b0;

  gift_ise_mc dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_imm(req_imm),
    .req_op_key_updstd(req_op_key_updstd), .req_op_permbits_step(req_op_permbits_step),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .flush(flush)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [31:0] rd;
    int          acc;  // cycle stamp of the accepting edge
    int          lat;  // edges from acceptance until rsp_valid is visible
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rdy_mode = 0;  // 0 random, 1 hold low, 2 hold high
  bit   seen = 1'b0;

  always @(posedge g_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: swapmove viewed as swapping bit pairs (i, i+A) for each set mask bit.
  function automatic logic [31:0] m_swap(input logic [31:0] x, input int a, input logic [31:0] m);
    logic [31:0] y;
    logic        b;
    y = x;
    for (int i = 0; i < 32; i++)
      if (m[i]) begin
        b = y[i];
        y[i] = y[i+a];
        y[i+a] = b;
      end
    return y;
  endfunction

  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[i] = x[(i + n) % 32];
    return y;
  endfunction

  function automatic logic [31:0] m_perm(input logic [31:0] x, input int n);
    logic [31:0] y;
    y = m_swap(x, 3, 32'h0a0a0a0a);
    y = m_swap(y, 6, 32'h00cc00cc);
    y = m_swap(y, 12, 32'h0000f0f0);
    y = m_swap(y, 24, 32'h000000ff);
    return m_rotr(y, n);
  endfunction

  function automatic logic [31:0] m_key(input logic [31:0] x);
    logic [31:0] y;
    y[3:0]   = x[15:12];
    y[15:4]  = x[11:0];
    y[29:16] = x[31:18];
    y[31:30] = x[17:16];
    return y;
  endfunction

  // Monitor: picks rsp_ready for the coming edge, then checks whatever the DUT presents.
  always @(negedge g_clk) begin
    case (rdy_mode)
      0:       rsp_ready = ($urandom_range(0, 3) != 0);
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rd=%h expected no response (t=%0t)", rsp_rd, $time);
      end else begin
        if (!seen) chk("rsp_latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
        chk("rsp_rd", rsp_rd, sb[0].rd);
        if (rsp_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end else begin
          seen = 1'b1;
        end
      end
    end else begin
      chk("rd_zero_when_idle", rsp_rd, 32'h0);
      seen = 1'b0;
    end
  end

  task automatic send(input logic [31:0] rs1, input logic [4:0] imm, input logic ku,
                      input logic pb, input logic [31:0] exp_rd, input bit push);
    int n;
    n = 0;
    @(negedge g_clk);
    while (!req_ready && n < 300) begin
      @(negedge g_clk);
      n++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 300 cycles");
      return;
    end
    req_rs1 = rs1;
    req_imm = imm;
    req_op_key_updstd = ku;
    req_op_permbits_step = pb;
    req_valid = 1'b1;
    @(posedge g_clk);
    #1;
    req_valid = 1'b0;
    if (push) sb.push_back('{exp_rd, cyc, (pb && !ku) ? PLAT : 0});
  endtask

  initial begin
    logic [31:0] rs;
    logic [4:0]  im;
    int          op;
    int          n;

    repeat (2) @(negedge g_clk);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_rd", rsp_rd, 32'h0);

    // Acceptance on the very first edge after release.
    g_resetn = 1'b1;
    req_rs1 = 32'h0000000f;
    req_op_key_updstd = 1'b1;
    req_op_permbits_step = 1'b0;
    req_valid = 1'b1;
    @(posedge g_clk);
    #1;
    req_valid = 1'b0;
    sb.push_back('{32'h000000f0, cyc, 0});
    chk("first_edge_accept", {31'b0, req_ready}, 32'd0);

    send(32'h0000f000, 5'd0, 1'b1, 1'b0, 32'h0000000f, 1'b1);
    send(32'h00000008, 5'd0, 1'b0, 1'b1, 32'h00000001, 1'b1);
    send(32'h00000008, 5'd1, 1'b0, 1'b1, 32'h80000000, 1'b1);
    send(32'hffffffff, 5'd7, 1'b0, 1'b1, 32'hffffffff, 1'b1);
    send(32'h12345678, 5'd9, 1'b1, 1'b1, 32'h00000000, 1'b1);
    send(32'h12345678, 5'd9, 1'b0, 1'b0, 32'h00000000, 1'b1);

    // Backpressure in DONE.
    send(32'h0000000f, 5'd0, 1'b1, 1'b0, 32'h000000f0, 1'b1);
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge g_clk);
      #1;
      chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rdy_mode = 2;
    @(negedge g_clk);
    @(posedge g_clk);
    #1;
    chk("release_req_ready", {31'b0, req_ready}, 32'd1);
    chk("release_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    rdy_mode = 0;

    // Flush while the permutation is at step 2.
    send(32'h89abcdef, 5'd3, 1'b0, 1'b1, 32'h0, 1'b0);
    @(posedge g_clk);
    @(posedge g_clk);
    #1;
    flush = 1'b1;
    @(posedge g_clk);
    #1;
    flush = 1'b0;
    chk("flush_sm_req_ready", {31'b0, req_ready}, 32'd1);
    chk("flush_sm_rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Flush coincident with a request in IDLE.
    @(negedge g_clk);
    req_rs1 = 32'h0000000f;
    req_op_key_updstd = 1'b1;
    req_op_permbits_step = 1'b0;
    req_valid = 1'b1;
    flush = 1'b1;
    @(posedge g_clk);
    #1;
    req_valid = 1'b0;
    flush = 1'b0;
    chk("flush_req_req_ready", {31'b0, req_ready}, 32'd1);
    chk("flush_req_rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Reset pulse while in ROT.
    send(32'h00000008, 5'd1, 1'b0, 1'b1, 32'h80000000, 1'b1);
    repeat (PLAT - 1) @(posedge g_clk);
    #1;
    g_resetn = 1'b0;
    #1;
    chk("rst_rot_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rot_rsp_rd", rsp_rd, 32'h0);
    chk("rst_rot_req_ready", {31'b0, req_ready}, 32'd1);
    sb.delete();
    @(negedge g_clk);
    g_resetn = 1'b1;
    send(32'hffffffff, 5'd7, 1'b0, 1'b1, 32'hffffffff, 1'b1);
    send(32'h0000000f, 5'd0, 1'b1, 1'b0, 32'h000000f0, 1'b1);

    for (int k = 0; k < 200; k++) begin
      rs = $urandom;
      im = 5'($urandom_range(0, 31));
      op = $urandom_range(0, 3);
      case (op)
        1:       send(rs, im, 1'b1, 1'b0, m_key(rs), 1'b1);
        2:       send(rs, im, 1'b0, 1'b1, m_perm(rs, int'(im)), 1'b1);
        default: send(rs, im, op == 3, op == 3, 32'h0, 1'b1);
      endcase
    end

    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge g_clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
    end
    repeat (3) @(negedge g_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
